snake_dir_ctrl: RTL and testbench

- Direction controller directly downstream of the four button edge-pulse stages (one `debounce_pulse` per button).
- Consumes 1-cycle press pulses and buffers legal turns in a small FIFO. Pops one turn per game step strobe.
- Outputs the committed snake heading to the movement/body-update logic.
- Prevents 180° reversals and swallows redundant presses, so fast double-taps between steps are neither lost nor self-colliding.

---
 rtl/snake_dir_ctrl_pkg.sv | 27 ++
 rtl/snake_dir_ctrl_if.sv | 44 ++++
 rtl/snake_turn_fifo.sv | 69 ++++++
 rtl/snake_dir_ctrl.sv | 117 +++++++++++
 tb/tb_snake_dir_ctrl.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/snake_dir_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : snake_pkg
// Purpose  : Shared definitions for the snake direction controller. Holds the
//            2-bit heading encoding, the default heading and the
//            reversal-detection helper.
// Revision : 1.0  initial release
// ============================================================================
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_t;

    localparam logic [1:0] DIR_INIT_DEFAULT = 2'b11;

    // Opposite headings share the axis bit (bit1) and differ in the sense
    // bit (bit0): UP/DOWN and LEFT/RIGHT.
    function automatic logic is_opposite(input logic [1:0] a, input logic [1:0] b);
        return (a[1] == b[1]) && (a[0] != b[0]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/snake_dir_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : snake_dir_ctrl_if
// Purpose  : Groups the controller's game-side signals.
//   game_en, pulse_up/down/left/right, step : requests into the controller
//   dir_o, turn_o, q_count_o, drop_o        : controller status
//   turn_cnt_o                              : only with SNAKE_DIR_STATS_EN
// Modports : master drives requests, slave (the controller) drives status.
// Revision : 1.0  initial release
// ============================================================================
interface snake_dir_ctrl_if #(
    parameter int QDEPTH = 2
) ();
    logic                      game_en;
    logic                      pulse_up;
    logic                      pulse_down;
    logic                      pulse_left;
    logic                      pulse_right;
    logic                      step;
    logic [1:0]                dir_o;
    logic                      turn_o;
    logic [$clog2(QDEPTH):0]   q_count_o;
    logic                      drop_o;
`ifdef SNAKE_DIR_STATS_EN
    logic [15:0]               turn_cnt_o;
`endif

    modport master (
        output game_en, pulse_up, pulse_down, pulse_left, pulse_right, step,
`ifdef SNAKE_DIR_STATS_EN
        input  turn_cnt_o,
`endif
        input  dir_o, turn_o, q_count_o, drop_o
    );

    modport slave (
        input  game_en, pulse_up, pulse_down, pulse_left, pulse_right, step,
`ifdef SNAKE_DIR_STATS_EN
        output turn_cnt_o,
`endif
        output dir_o, turn_o, q_count_o, drop_o
    );
endinterface
`default_nettype wire

// File: rtl/snake_turn_fifo.sv
`default_nettype none
// ============================================================================
// Module   : snake_turn_fifo
// Purpose  : Small FIFO of pending 2-bit turns. Exposes both the head (next
//            turn to commit) and the tail (most recently accepted turn).
// Ports    : clk, rst (async active-low), i_flush (sync clear), i_push,
//            i_pop, i_data, o_head, o_tail, o_count, o_full, o_empty
// Revision : 1.0  initial release
// ============================================================================
module snake_turn_fifo #(
    parameter int QDEPTH = 2,
    localparam int PTR_W = $clog2(QDEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_flush,
    input  wire logic             i_push,
    input  wire logic             i_pop,
    input  wire logic [1:0]       i_data,
    output logic      [1:0]       o_head,
    output logic      [1:0]       o_tail,
    output logic      [CNT_W-1:0] o_count,
    output logic                  o_full,
    output logic                  o_empty
);
    localparam logic [CNT_W-1:0] c_DEPTH = CNT_W'(QDEPTH);

    logic [1:0]       r_mem [QDEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] w_tail_ptr;

    // Depth is a power of two, so pointer arithmetic wraps naturally.
    assign w_tail_ptr = r_wr_ptr - 1'b1;
    assign o_head     = r_mem[r_rd_ptr];
    assign o_tail     = r_mem[w_tail_ptr];
    assign o_count    = r_count;
    assign o_full     = (r_count == c_DEPTH);
    assign o_empty    = (r_count == '0);

    always_ff @(posedge clk) begin
        if (i_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/snake_dir_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : snake_dir_ctrl
// Purpose  : Snake heading controller. Accepts button press pulses, filters
//            redundant and reversing turns, buffers legal turns and commits
//            one turn per game step.
// Ports    : clk, rst (async active-low), bus (snake_dir_ctrl_if.slave)
// Macro    : SNAKE_DIR_STATS_EN adds a saturating 16-bit turn counter
//            (bus.turn_cnt_o).
// Revision : 1.0  initial release
// ============================================================================
module snake_dir_ctrl
    import snake_pkg::*;
#(
    parameter int         QDEPTH   = 2,
    parameter logic [1:0] DIR_INIT = DIR_INIT_DEFAULT
) (
    input  wire logic       clk,
    input  wire logic       rst,
    snake_dir_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(QDEPTH) + 1;

    logic             w_req_valid;
    logic [1:0]       w_req_dir;
    logic [1:0]       w_ref_dir;
    logic             w_legal;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic [1:0]       w_head;
    logic [1:0]       w_tail;
    logic [CNT_W-1:0] w_count;
    logic             w_full;
    logic             w_empty;

    logic [1:0]       r_dir;
    logic             r_turn;
    logic             r_drop;

    // Fixed priority: up > down > left > right.
    always_comb begin
        w_req_valid = 1'b1;
        w_req_dir   = DIR_UP;
        if (bus.pulse_up)          w_req_dir = DIR_UP;
        else if (bus.pulse_down)   w_req_dir = DIR_DOWN;
        else if (bus.pulse_left)   w_req_dir = DIR_LEFT;
        else if (bus.pulse_right)  w_req_dir = DIR_RIGHT;
        else                       w_req_valid = 1'b0;
    end

    // Legality is judged against the last queued turn so chained presses
    // between steps cannot build a reversal.
    assign w_ref_dir = w_empty ? r_dir : w_tail;
    assign w_legal   = w_req_valid && (w_req_dir != w_ref_dir)
                       && !is_opposite(w_req_dir, w_ref_dir);
    assign w_pop     = bus.game_en && bus.step && !w_empty;
    // A full FIFO still accepts when the same cycle's step frees a slot.
    assign w_push    = bus.game_en && w_legal && (!w_full || w_pop);
    assign w_drop    = bus.game_en && w_legal && w_full && !w_pop;

    snake_turn_fifo #(
        .QDEPTH (QDEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (!bus.game_en),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_req_dir),
        .o_head  (w_head),
        .o_tail  (w_tail),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dir  <= DIR_INIT;
            r_turn <= 1'b0;
            r_drop <= 1'b0;
        end else if (!bus.game_en) begin
            r_dir  <= DIR_INIT;
            r_turn <= 1'b0;
            r_drop <= 1'b0;
        end else begin
            if (w_pop) r_dir <= w_head;
            // Every queued entry differs from its predecessor, so a pop
            // always changes the heading.
            r_turn <= w_pop;
            r_drop <= w_drop;
        end
    end

`ifdef SNAKE_DIR_STATS_EN
    logic [15:0] r_turn_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_turn_cnt <= '0;
        end else if (!bus.game_en) begin
            r_turn_cnt <= '0;
        end else if (r_turn && (r_turn_cnt != 16'hFFFF)) begin
            r_turn_cnt <= r_turn_cnt + 16'd1;
        end
    end

    assign bus.turn_cnt_o = r_turn_cnt;
`endif

    assign bus.dir_o     = r_dir;
    assign bus.turn_o    = r_turn;
    assign bus.q_count_o = w_count;
    assign bus.drop_o    = r_drop;
endmodule
`default_nettype wire

// File: tb/tb_snake_dir_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_snake_dir_ctrl
// Purpose  : Self-checking bench for snake_dir_ctrl: directed vector table
//            followed by random stimulus against a queue-based model.
// Revision : 1.0  initial release
// ============================================================================
module tb_snake_dir_ctrl;
    localparam int QD = 2;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    snake_dir_ctrl_if #(.QDEPTH(QD)) bus ();

    snake_dir_ctrl #(
        .QDEPTH   (QD),
        .DIR_INIT (2'b11)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic en, up, dn, lf, rt, st;
        int   dir, turn, cnt, drop;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic en, up, dn, lf, rt, st,
                                input int dir, turn, cnt, drop);
        vec_t v;
        v.en = en; v.up = up; v.dn = dn; v.lf = lf; v.rt = rt; v.st = st;
        v.dir = dir; v.turn = turn; v.cnt = cnt; v.drop = drop;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic en, up, dn, lf, rt, st);
        @(negedge clk);
        bus.game_en     = en;
        bus.pulse_up    = up;
        bus.pulse_down  = dn;
        bus.pulse_left  = lf;
        bus.pulse_right = rt;
        bus.step        = st;
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input int dir, turn, cnt, drop);
        check({tag, ".dir"},  int'(bus.dir_o),     dir);
        check({tag, ".turn"}, int'(bus.turn_o),    turn);
        check({tag, ".cnt"},  int'(bus.q_count_o), cnt);
        check({tag, ".drop"}, int'(bus.drop_o),    drop);
    endtask

    // ---------------- behavioural reference model ----------------
    int m_q[$];
    int m_dir, m_turn, m_drop, m_tcnt;

    task automatic model_reset();
        m_q.delete();
        m_dir = 3; m_turn = 0; m_drop = 0; m_tcnt = 0;
    endtask

    task automatic model_step(input logic en, up, dn, lf, rt, st);
        int  req, refd;
        bit  valid, legal, pop;
        if (!en) begin
            model_reset();
            return;
        end
        // turn counter counts turns already visible on the output
        if (m_turn != 0 && m_tcnt < 65535) m_tcnt++;
        valid = 1; req = 0;
        if (up) req = 0; else if (dn) req = 1; else if (lf) req = 2;
        else if (rt) req = 3; else valid = 0;
        refd  = (m_q.size() > 0) ? m_q[m_q.size()-1] : m_dir;
        legal = valid && (req != refd) && ((req / 2) != (refd / 2));
        pop   = st && (m_q.size() > 0);
        m_drop = (legal && m_q.size() >= QD && !pop) ? 1 : 0;
        m_turn = pop ? 1 : 0;
        if (pop) m_dir = m_q.pop_front();
        if (legal && m_drop == 0) m_q.push_back(req);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        bus.game_en = 1'b1; bus.pulse_up = 1'b0; bus.pulse_down = 1'b0;
        bus.pulse_left = 1'b0; bus.pulse_right = 1'b0; bus.step = 1'b0;
        repeat (2) @(negedge clk);
        check_outs("reset", 3, 0, 0, 0);
        rst = 1'b1;

        //                 en u d l r st   dir turn cnt drop
        vecs.push_back(mk(1, 0,0,0,0, 1,   3, 0, 0, 0)); // idle steps
        vecs.push_back(mk(1, 0,0,0,0, 1,   3, 0, 0, 0));
        vecs.push_back(mk(1, 0,0,0,0, 1,   3, 0, 0, 0));
        vecs.push_back(mk(1, 1,0,0,0, 0,   3, 0, 1, 0)); // up queued
        vecs.push_back(mk(1, 0,0,0,0, 1,   0, 1, 0, 0)); // step -> UP
        vecs.push_back(mk(1, 0,0,0,0, 0,   0, 0, 0, 0));
        vecs.push_back(mk(0, 0,0,0,0, 0,   3, 0, 0, 0)); // flush to RIGHT
        vecs.push_back(mk(1, 0,0,1,0, 0,   3, 0, 0, 0)); // reverse rejected
        vecs.push_back(mk(1, 0,0,0,1, 0,   3, 0, 0, 0)); // same rejected
        vecs.push_back(mk(1, 1,0,0,0, 0,   3, 0, 1, 0)); // up
        vecs.push_back(mk(1, 0,0,1,0, 0,   3, 0, 2, 0)); // left (vs tail up)
        vecs.push_back(mk(1, 0,1,0,0, 0,   3, 0, 2, 1)); // down dropped
        vecs.push_back(mk(1, 0,0,0,0, 1,   0, 1, 1, 0));
        vecs.push_back(mk(1, 0,0,0,0, 1,   2, 1, 0, 0));
        vecs.push_back(mk(1, 1,0,0,0, 0,   2, 0, 1, 0));
        vecs.push_back(mk(1, 0,0,1,0, 0,   2, 0, 2, 0)); // full
        vecs.push_back(mk(1, 0,1,0,0, 1,   0, 1, 2, 0)); // full+step+push
        vecs.push_back(mk(1, 0,0,0,0, 1,   2, 1, 1, 0));
        vecs.push_back(mk(1, 0,0,0,0, 1,   1, 1, 0, 0));
        vecs.push_back(mk(1, 0,0,0,1, 0,   1, 0, 1, 0));
        vecs.push_back(mk(1, 0,0,0,0, 1,   3, 1, 0, 0));
        vecs.push_back(mk(1, 1,0,1,0, 0,   3, 0, 1, 0)); // up wins over left
        vecs.push_back(mk(0, 1,0,0,0, 1,   3, 0, 0, 0)); // disabled: flush
        vecs.push_back(mk(1, 0,0,0,0, 0,   3, 0, 0, 0));
        vecs.push_back(mk(1, 1,0,0,0, 1,   3, 0, 1, 0)); // step on empty + push
        vecs.push_back(mk(1, 0,0,0,0, 0,   3, 0, 1, 0));
        vecs.push_back(mk(1, 0,0,0,0, 1,   0, 1, 0, 0)); // applies next step

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].en, vecs[i].up, vecs[i].dn, vecs[i].lf, vecs[i].rt, vecs[i].st);
            check_outs($sformatf("vec%0d", i), vecs[i].dir, vecs[i].turn,
                       vecs[i].cnt, vecs[i].drop);
        end

        // Asynchronous reset with a non-empty queue, checked before any edge.
        drive(1, 0, 0, 1, 0, 0);
        @(negedge clk);
        bus.pulse_left = 1'b0;
        #2 rst = 1'b0;
        #1 check_outs("async_rst", 3, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();

        for (int n = 0; n < 3000; n++) begin
            logic en, up, dn, lf, rt, st;
            en = ($urandom_range(0, 31) != 0);
            up = ($urandom_range(0, 3) == 0);
            dn = ($urandom_range(0, 3) == 0);
            lf = ($urandom_range(0, 3) == 0);
            rt = ($urandom_range(0, 3) == 0);
            st = ($urandom_range(0, 4) == 0);
            drive(en, up, dn, lf, rt, st);
            model_step(en, up, dn, lf, rt, st);
            check_outs("rand", m_dir, m_turn, m_q.size(), m_drop);
`ifdef SNAKE_DIR_STATS_EN
            check("rand.turn_cnt", int'(bus.turn_cnt_o), m_tcnt);
`endif
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
